layer_vn_update_6: RTL and testbench
====================================

# layer_vn_update_6

Variable-node side of a layered min-sum decoder row, paired with the degree-6 check node unit. It forms the six variable-to-check messages for one layer row by subtracting the previous check-to-variable messages from the posterior (APP) values, then feeds the CNU. It holds the unsaturated differences for the CNU pipeline latency and adds the CNU's new check-to-variable messages back to produce the updated posteriors. The block streams one row per cycle and sits between the APP memory and the CNU.

## Interface
- CN_DEGREE, 6, lanes per row (check-node degree)
- QUAN_SIZE, 4, message width, sign-magnitude (MSB = sign, 1 = negative)
- APP_SIZE, 6, posterior width, two's complement
- CNU_LAT, 4, cycles from v2c_valid to the matching c2v_new_valid
- sys_clk  in  1  clock; all logic is sampled on the rising edge
- rstn  in  1  synchronous, active-low reset
- in_valid  in  1  app_in and c2v_old carry one row this cycle
- app_in  in  CN_DEGREE*APP_SIZE  posteriors; lane i is in bits [i*APP_SIZE +: APP_SIZE]
- c2v_old  in  CN_DEGREE*QUAN_SIZE  previous check-to-variable messages for the row
- v2c_out  out  CN_DEGREE*QUAN_SIZE  variable-to-check messages sent to the CNU
- v2c_valid  out  1  v2c_out is valid
- v2c_sat  out  1  at least one lane of v2c_out was clipped; qualified by v2c_valid
- c2v_new_valid  in  1  the CNU presents c2v_new
- c2v_new  in  CN_DEGREE*QUAN_SIZE  new check-to-variable messages from the CNU
- app_out  out  CN_DEGREE*APP_SIZE  updated posteriors
- app_out_valid  out  1  app_out is valid
- app_sat  out  1  at least one lane of app_out was clipped; qualified by app_out_valid
- align_err  out  1  sticky; c2v_new_valid did not line up with the delay-line head

## Operation
- Sign-magnitude to two's-complement conversion: the code 1000 (negative zero) decodes as 0.
- Stage A, registered, per lane:
  - diff = app_in − c2v_old, computed in APP_SIZE+1 bits (range ±39 at default widths, no wrap).
  - v2c = diff saturated to ±(2^(QUAN_SIZE−1)−1) = ±7, then encoded as sign-magnitude.
  - Zero is always encoded 0000; the encoder never emits negative zero.
  - v2c_sat = OR over lanes of the per-lane clip indication.
- Delay line: CNU_LAT entries, each holding the unsaturated diff of all lanes (CN_DEGREE*(APP_SIZE+1) bits) plus a valid bit.
  - It shifts every cycle.
  - Stage A's output, including its valid bit, is written into the tail.
- Stage B, registered, per lane:
  - Computed when c2v_new_valid is high.
  - sum = head diff + c2v_new, computed in APP_SIZE+1 bits (range ±46).
  - app_out = sum saturated to ±(2^(APP_SIZE−1)−1) = ±31.
  - app_sat = OR over lanes of the per-lane clip indication.
- Alignment check:
  - If c2v_new_valid differs from the head valid bit in any cycle, align_err is set and held until reset.
  - On that error, Stage B still fires on c2v_new_valid and uses whatever is at the head.
- There is no backpressure: the CNU accepts one row per cycle, and the upstream source must honour the fixed latency.

## Timing
- Latency: in_valid at cycle t gives v2c_valid at t+1, c2v_new_valid is expected at t+1+CNU_LAT, and app_out_valid follows at t+2+CNU_LAT.
- Throughput: one row per cycle; back-to-back in_valid is fully supported.
- Gaps in in_valid appear as gaps at both outputs.
- Outputs hold their last value while the corresponding valid is low; v2c_sat and app_sat are 0 whenever their valid is 0.
- Reset: v2c_out, v2c_valid, v2c_sat, app_out, app_out_valid, app_sat and align_err all go to 0, and every delay-line valid bit is cleared.
- Reset asserted mid-stream discards all in-flight rows; the first row after rstn rises follows the normal latency.
- A c2v_new_valid that arrives while rstn is low is ignored.

## Structure
- Package ldpc_msg_pkg holds:
  - constants QUAN_SIZE, APP_SIZE and MAG_SIZE = QUAN_SIZE−1;
  - functions sm2tc(msg) and tc2sm(val);
  - a generic symmetric-saturation function sat(val, width) that returns the clipped value and a clip flag.
- Sub-module vn_delay_line: parameterised by WIDTH and DEPTH, a shift register with valid, synchronous reset clearing only the valid bits.

## Test plan
- Basic lane: app = 10, c2v_old = 0011. Expect v2c_out = 0111 at t+1 with v2c_sat = 0. Then c2v_new = 1010 gives app_out = 5 at t+6, app_sat = 0.
- Saturation on both sides: app = 31, c2v_old = 1101.
  - diff = 36, so v2c = 0111 and v2c_sat = 1.
  - c2v_new = 0111 gives sum = 43, so app_out = 31 and app_sat = 1.
- Negative and negative-zero: app = −20, c2v_old = 0010.
  - diff = −22, so v2c = 1111.
  - c2v_new = 1000 gives app_out = −22.
  - A lane with app = 0, c2v_old = 1000 gives v2c = 0000.
- Streaming: 5 back-to-back rows with a model CNU at CNU_LAT = 4.
  - Expect 5 consecutive app_out_valid pulses starting at t+6, each matching its golden row.
  - align_err stays 0.
- Misalignment and reset: c2v_new_valid one cycle early.
  - Expect align_err = 1 and held.
  - Then assert rstn = 0 for one cycle mid-stream: all outputs go to 0, align_err clears, and no app_out_valid appears for rows that were in flight.

Source files
------------

// File: rtl/ldpc_msg_pkg.sv
// ldpc_msg_pkg: message formats shared by the layered min-sum datapath.
//   QUAN_SIZE : width of v2c/c2v messages, sign-magnitude (MSB = sign)
//   APP_SIZE  : width of posterior (APP) values, two's complement
//   DIFF_W    : APP_SIZE+1, enough to hold app - c2v or diff + c2v unwrapped
//   sm2tc     : sign-magnitude message -> DIFF_W two's complement
//   tc2sm     : already-saturated two's complement -> sign-magnitude
//   sat       : symmetric clip to +/-(2^(width-1)-1) with clip flag
package ldpc_msg_pkg;

  localparam int QUAN_SIZE = 4;
  localparam int APP_SIZE  = 6;
  localparam int MAG_SIZE  = QUAN_SIZE - 1;
  localparam int DIFF_W    = APP_SIZE + 1;

  typedef struct packed {
    logic signed [DIFF_W-1:0] val;
    logic                     clip;
  } sat_t;

  // Negative zero (1000) falls out as -0 = 0.
  function automatic logic signed [DIFF_W-1:0] sm2tc(input logic [QUAN_SIZE-1:0] msg);
    logic signed [DIFF_W-1:0] mag;
    mag = $signed({{(DIFF_W-MAG_SIZE){1'b0}}, msg[MAG_SIZE-1:0]});
    return msg[QUAN_SIZE-1] ? -mag : mag;
  endfunction

  // Caller guarantees |val| <= 2^MAG_SIZE-1. A negative value always has a
  // non-zero magnitude, so negative zero is never produced.
  function automatic logic [QUAN_SIZE-1:0] tc2sm(input logic signed [DIFF_W-1:0] val);
    logic [MAG_SIZE-1:0] mag;
    mag = val[DIFF_W-1] ? MAG_SIZE'(-val) : MAG_SIZE'(val);
    return {val[DIFF_W-1], mag};
  endfunction

  function automatic sat_t sat(input logic signed [DIFF_W-1:0] val, input int width);
    logic signed [DIFF_W-1:0] lim;
    sat_t r;
    lim    = DIFF_W'((1 <<< (width - 1)) - 1);
    r.val  = val;
    r.clip = 1'b0;
    if (val > lim) begin
      r.val  = lim;
      r.clip = 1'b1;
    end else if (val < -lim) begin
      r.val  = -lim;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vn_delay_line.sv
// vn_delay_line: fixed-depth shift register with a valid bit per entry.
//   sys_clk, rstn : clock, synchronous active-low reset (clears valids only)
//   d_i, vld_i    : tail entry, written every cycle
//   d_o, vld_o    : head entry, DEPTH cycles after it was written
module vn_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] d_o,
  output logic             vld_o
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            vld_pipe_q;

  // Data needs no reset: it is only ever consumed alongside its valid bit.
  always_ff @(posedge sys_clk) begin
    for (int i = DEPTH - 1; i > 0; i--) data_q[i] <= data_q[i-1];
    data_q[0] <= d_i;
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) vld_pipe_q[i] <= vld_pipe_q[i-1];
      vld_pipe_q[0] <= vld_i;
    end
  end

  assign d_o   = data_q[DEPTH-1];
  assign vld_o = vld_pipe_q[DEPTH-1];

endmodule

// File: rtl/layer_vn_update_6.sv
// layer_vn_update_6: variable-node half of a degree-6 layered min-sum row.
//   Stage A : v2c = sat7(app_in - c2v_old) in sign-magnitude, to the CNU.
//   Delay   : unsaturated diffs held CNU_LAT cycles to meet the CNU answer.
//   Stage B : app_out = sat31(diff + c2v_new) when c2v_new_valid.
// Ports:
//   sys_clk, rstn            clock, synchronous active-low reset
//   in_valid, app_in, c2v_old  incoming row
//   v2c_out, v2c_valid, v2c_sat  messages to the CNU
//   c2v_new_valid, c2v_new   CNU response
//   app_out, app_out_valid, app_sat  updated posteriors
//   align_err                sticky CNU/delay-line misalignment flag
module layer_vn_update_6
  import ldpc_msg_pkg::*;
#(
  parameter int CN_DEGREE = 6,
  parameter int CNU_LAT   = 4
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  input  logic [CN_DEGREE*APP_SIZE-1:0]  app_in,
  input  logic [CN_DEGREE*QUAN_SIZE-1:0] c2v_old,
  output logic [CN_DEGREE*QUAN_SIZE-1:0] v2c_out,
  output logic                           v2c_valid,
  output logic                           v2c_sat,
  input  logic                           c2v_new_valid,
  input  logic [CN_DEGREE*QUAN_SIZE-1:0] c2v_new,
  output logic [CN_DEGREE*APP_SIZE-1:0]  app_out,
  output logic                           app_out_valid,
  output logic                           app_sat,
  output logic                           align_err
);

  logic [CN_DEGREE-1:0][QUAN_SIZE-1:0] v2c_d, v2c_q;
  logic [CN_DEGREE-1:0][DIFF_W-1:0]    diff_d, diff_q, head_diff;
  logic [CN_DEGREE-1:0][APP_SIZE-1:0]  app_d, app_q;
  logic [CN_DEGREE-1:0]                clip_v, clip_a;
  logic                                v2c_vld_q, v2c_sat_q;
  logic                                app_vld_q, app_sat_q, align_err_q;
  logic                                head_vld;

  for (genvar g = 0; g < CN_DEGREE; g++) begin : g_lane
    logic signed [APP_SIZE-1:0] app_l;
    logic signed [DIFF_W-1:0]   diff_l, sum_l;
    sat_t                       vs, as;
    logic                       lane_unused;

    assign app_l  = app_in[g*APP_SIZE +: APP_SIZE];
    assign diff_l = $signed({app_l[APP_SIZE-1], app_l}) - sm2tc(c2v_old[g*QUAN_SIZE +: QUAN_SIZE]);
    assign vs     = sat(diff_l, QUAN_SIZE);

    assign diff_d[g] = diff_l;
    assign v2c_d[g]  = tc2sm(vs.val);
    assign clip_v[g] = vs.clip;

    assign sum_l     = $signed(head_diff[g]) + sm2tc(c2v_new[g*QUAN_SIZE +: QUAN_SIZE]);
    assign as        = sat(sum_l, APP_SIZE);
    // After a +/-31 clip the top bit is just a sign copy.
    assign app_d[g]  = as.val[APP_SIZE-1:0];
    assign lane_unused = as.val[DIFF_W-1];
    assign clip_a[g] = as.clip;
  end

  // Stage A: data holds when idle, sat flag only meaningful with valid.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      v2c_q     <= '0;
      diff_q    <= '0;
      v2c_vld_q <= 1'b0;
      v2c_sat_q <= 1'b0;
    end else begin
      v2c_vld_q <= in_valid;
      v2c_sat_q <= in_valid & (|clip_v);
      if (in_valid) begin
        v2c_q  <= v2c_d;
        diff_q <= diff_d;
      end
    end
  end

  vn_delay_line #(
    .WIDTH (CN_DEGREE*DIFF_W),
    .DEPTH (CNU_LAT)
  ) u_dly (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .d_i     (diff_q),
    .vld_i   (v2c_vld_q),
    .d_o     (head_diff),
    .vld_o   (head_vld)
  );

  // Stage B fires on the CNU's valid even when misaligned; align_err records it.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      app_q       <= '0;
      app_vld_q   <= 1'b0;
      app_sat_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      app_vld_q <= c2v_new_valid;
      app_sat_q <= c2v_new_valid & (|clip_a);
      if (c2v_new_valid) app_q <= app_d;
      if (c2v_new_valid != head_vld) align_err_q <= 1'b1;
    end
  end

  assign v2c_out       = v2c_q;
  assign v2c_valid     = v2c_vld_q;
  assign v2c_sat       = v2c_sat_q;
  assign app_out       = app_q;
  assign app_out_valid = app_vld_q;
  assign app_sat       = app_sat_q;
  assign align_err     = align_err_q;

endmodule

// File: tb/tb_layer_vn_update_6.sv
module tb_layer_vn_update_6;

  localparam int ND = 6;
  localparam int QS = 4;
  localparam int AS = 6;

  logic             sys_clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic [ND*AS-1:0] app_in;
  logic [ND*QS-1:0] c2v_old;
  logic [ND*QS-1:0] v2c_out;
  logic             v2c_valid, v2c_sat;
  logic             c2v_new_valid;
  logic [ND*QS-1:0] c2v_new;
  logic [ND*AS-1:0] app_out;
  logic             app_out_valid, app_sat, align_err;

  layer_vn_update_6 dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .app_in        (app_in),
    .c2v_old       (c2v_old),
    .v2c_out       (v2c_out),
    .v2c_valid     (v2c_valid),
    .v2c_sat       (v2c_sat),
    .c2v_new_valid (c2v_new_valid),
    .c2v_new       (c2v_new),
    .app_out       (app_out),
    .app_out_valid (app_out_valid),
    .app_sat       (app_sat),
    .align_err     (align_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         app[ND];
    logic [3:0] old[ND];
    logic [3:0] nw[ND];
    logic [3:0] v2c[ND];
    logic       vsat;
    int         aout[ND];
    logic       asat;
  } vec_t;

  vec_t vecs[5];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_row(input int k);
    int a;
    for (int i = 0; i < ND; i++) begin
      a = vecs[k].app[i];
      app_in[i*AS +: AS]  = a[AS-1:0];
      c2v_old[i*QS +: QS] = vecs[k].old[i];
    end
  endtask

  task automatic drive_c2v(input int k);
    for (int i = 0; i < ND; i++) c2v_new[i*QS +: QS] = vecs[k].nw[i];
  endtask

  function automatic logic [ND*QS-1:0] exp_v2c(input int k);
    logic [ND*QS-1:0] w;
    for (int i = 0; i < ND; i++) w[i*QS +: QS] = vecs[k].v2c[i];
    return w;
  endfunction

  function automatic logic [ND*AS-1:0] exp_app(input int k);
    logic [ND*AS-1:0] w;
    int a;
    for (int i = 0; i < ND; i++) begin
      a = vecs[k].aout[i];
      w[i*AS +: AS] = a[AS-1:0];
    end
    return w;
  endfunction

  // One isolated row through the full latency with a well-timed CNU answer.
  task automatic run_vec(input int k);
    string s;
    s = $sformatf("v%0d", k);
    drive_row(k);
    in_valid = 1'b1;
    step();                                   // E0: stage A
    in_valid = 1'b0;
    chk({s, " v2c_valid"}, 64'(v2c_valid), 64'd1);
    chk({s, " v2c_out"},   64'(v2c_out),   64'(exp_v2c(k)));
    chk({s, " v2c_sat"},   64'(v2c_sat),   64'(vecs[k].vsat));
    step(); step(); step(); step();           // E1..E4: head now valid
    chk({s, " early app_out_valid"}, 64'(app_out_valid), 64'd0);
    drive_c2v(k);
    c2v_new_valid = 1'b1;
    step();                                   // E5: stage B
    c2v_new_valid = 1'b0;
    chk({s, " app_out_valid"}, 64'(app_out_valid), 64'd1);
    chk({s, " app_out"},       64'(app_out),       64'(exp_app(k)));
    chk({s, " app_sat"},       64'(app_sat),       64'(vecs[k].asat));
    chk({s, " align_err"},     64'(align_err),     64'd0);
    step();
    chk({s, " app_out hold"},  64'(app_out),       64'(exp_app(k)));
    chk({s, " app_sat idle"},  64'(app_sat),       64'd0);
  endtask

  initial begin
    // Hand-computed rows: app, c2v_old, c2v_new -> v2c, v2c_sat, app_out, app_sat
    vecs[0].app  = '{10, 0, 1, -3, 5, -7};
    vecs[0].old  = '{4'b0011, 4'b1000, 4'b0001, 4'b0010, 4'b1001, 4'b0000};
    vecs[0].nw   = '{4'b1010, 4'b0000, 4'b0011, 4'b0001, 4'b1110, 4'b0111};
    vecs[0].v2c  = '{4'b0111, 4'b0000, 4'b0000, 4'b1101, 4'b0110, 4'b1111};
    vecs[0].vsat = 1'b0;
    vecs[0].aout = '{5, 0, 3, -4, 0, 0};
    vecs[0].asat = 1'b0;

    vecs[1].app  = '{31, 0, 0, 0, 0, 0};
    vecs[1].old  = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1].nw   = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1].v2c  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1].vsat = 1'b1;
    vecs[1].aout = '{31, 0, 0, 0, 0, 0};
    vecs[1].asat = 1'b1;

    vecs[2].app  = '{-20, 0, -32, 0, 0, 0};
    vecs[2].old  = '{4'b0010, 4'b1000, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
    vecs[2].nw   = '{4'b1000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[2].v2c  = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[2].vsat = 1'b1;
    vecs[2].aout = '{-22, 0, -31, 0, 0, 0};
    vecs[2].asat = 1'b1;

    vecs[3].app  = '{8, 0, 0, 0, 0, 0};
    vecs[3].old  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3].nw   = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3].v2c  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[3].vsat = 1'b1;
    vecs[3].aout = '{1, 0, 0, 0, 0, 0};
    vecs[3].asat = 1'b0;

    vecs[4].app  = '{7, -7, 31, -31, 8, -8};
    vecs[4].old  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1001};
    vecs[4].nw   = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    vecs[4].v2c  = '{4'b0111, 4'b1111, 4'b0111, 4'b1111, 4'b0111, 4'b1111};
    vecs[4].vsat = 1'b1;
    vecs[4].aout = '{7, -7, 31, -31, 7, -7};
    vecs[4].asat = 1'b0;

    rstn = 1'b0; in_valid = 1'b0; c2v_new_valid = 1'b0;
    app_in = '0; c2v_old = '0; c2v_new = '0;
    step(); step();
    rstn = 1'b1;
    chk("rst v2c_valid", 64'(v2c_valid), 64'd0);
    chk("rst v2c_out",   64'(v2c_out),   64'd0);
    chk("rst app_out",   64'(app_out),   64'd0);
    chk("rst app_valid", 64'(app_out_valid), 64'd0);
    chk("rst align_err", 64'(align_err), 64'd0);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Streaming: 5 back-to-back rows, model CNU answers CNU_LAT after v2c_valid.
    for (int p = 0; p < 13; p++) begin
      if (p >= 1) begin
        chk($sformatf("strm p%0d v2c_valid", p), 64'(v2c_valid), 64'(p - 1 < 5));
        if (p - 1 < 5) chk($sformatf("strm p%0d v2c_out", p), 64'(v2c_out), 64'(exp_v2c(p - 1)));
        else           chk($sformatf("strm p%0d v2c_sat idle", p), 64'(v2c_sat), 64'd0);
        chk($sformatf("strm p%0d app_valid", p), 64'(app_out_valid), 64'(p >= 6 && p <= 10));
        if (p >= 6 && p <= 10) begin
          chk($sformatf("strm p%0d app_out", p), 64'(app_out), 64'(exp_app(p - 6)));
          chk($sformatf("strm p%0d app_sat", p), 64'(app_sat), 64'(vecs[p-6].asat));
        end
      end
      in_valid = (p < 5);
      if (p < 5) drive_row(p);
      c2v_new_valid = (p >= 5 && p < 10);
      if (p >= 5 && p < 10) drive_c2v(p - 5);
      step();
    end
    chk("strm align_err", 64'(align_err), 64'd0);

    // Misalignment: CNU answers one cycle early.
    drive_row(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    drive_c2v(0);
    c2v_new_valid = 1'b1;
    step();
    c2v_new_valid = 1'b0;
    chk("mis align_err set", 64'(align_err), 64'd1);
    step(); step(); step();
    chk("mis align_err held", 64'(align_err), 64'd1);

    // Reset mid-stream with a stray CNU valid during reset.
    drive_row(1); in_valid = 1'b1; step();
    drive_row(2); step();
    rstn = 1'b0; drive_row(3); c2v_new_valid = 1'b1;
    step();
    rstn = 1'b1; in_valid = 1'b0; c2v_new_valid = 1'b0;
    chk("mrst v2c_out",    64'(v2c_out),       64'd0);
    chk("mrst v2c_valid",  64'(v2c_valid),     64'd0);
    chk("mrst v2c_sat",    64'(v2c_sat),       64'd0);
    chk("mrst app_out",    64'(app_out),       64'd0);
    chk("mrst app_valid",  64'(app_out_valid), 64'd0);
    chk("mrst app_sat",    64'(app_sat),       64'd0);
    chk("mrst align_err",  64'(align_err),     64'd0);
    begin
      logic seen_v;
      seen_v = 1'b0;
      for (int c = 0; c < 8; c++) begin
        step();
        seen_v = seen_v | app_out_valid | v2c_valid;
      end
      chk("mrst no in-flight output", 64'(seen_v), 64'd0);
      chk("mrst align_err quiet", 64'(align_err), 64'd0);
    end

    // First row after reset follows the normal latency.
    run_vec(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
